peridot_config_i2c_arb: RTL and testbench

//  Bus arbiter sharing the single board I2C bus (serial EEPROM, UID area) between two I2C masters:

---
 rtl/peridot_config_i2c_arb_pkg.sv | 15 +
 rtl/peridot_i2c_cond_det.sv | 54 +++++
 rtl/peridot_config_i2c_arb.sv | 144 ++++++++++++++
 tb/tb_peridot_config_i2c_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peridot_config_i2c_arb_pkg.sv
// Shared definitions for the board I2C bus arbiter: FSM encoding and default timing constants.
package peridot_config_i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int DEF_BUS_FREE_CYCLE = 64;
  localparam int DEF_TIMEOUT_CYCLE  = 1048576;
  localparam int DEF_SYNC_STAGES    = 2;

endpackage

// File: rtl/peridot_i2c_cond_det.sv
// Synchronizes the physical SCL/SDA levels into clk and flags START, STOP and SCL edges.
module peridot_i2c_cond_det
  import peridot_config_i2c_arb_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_valid,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_edge
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_vld      <= '0;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer contents are reset values, not bus samples, until a real sample has propagated.
  assign o_valid    = r_vld[SYNC_STAGES-1];
  assign o_scl      = w_scl;
  assign o_sda      = w_sda;
  assign o_start    = o_valid & w_scl & r_sda_d & ~w_sda;
  assign o_stop     = o_valid & w_scl & ~r_sda_d & w_sda;
  assign o_scl_edge = o_valid & (w_scl ^ r_scl_d);

endmodule

// File: rtl/peridot_config_i2c_arb.sv
// Two-master arbiter for the shared board I2C bus; grants whole START..STOP transactions.
// state      | meaning
// ST_IDLE    | no owner, bus drives released, waiting for free time and a request
// ST_GRANT0  | master 0 owns the bus, its drives are muxed to the pads
// ST_GRANT1  | master 1 owns the bus, its drives are muxed to the pads
// ST_RELEASE | one cycle with pads released, free counter restarts
module peridot_config_i2c_arb
  import peridot_config_i2c_arb_pkg::*;
#(
  parameter int BUS_FREE_CYCLE = DEF_BUS_FREE_CYCLE,
  parameter int TIMEOUT_CYCLE  = DEF_TIMEOUT_CYCLE,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  output logic m0_grant,
  input  logic m0_scl_o,
  input  logic m0_sda_o,
  input  logic m1_req,
  output logic m1_grant,
  input  logic m1_scl_o,
  input  logic m1_sda_o,
  input  logic bus_scl_i,
  input  logic bus_sda_i,
  output logic bus_scl_o,
  output logic bus_sda_o,
  output logic bus_busy,
  output logic timeout
);

  localparam int FREE_W = $clog2(BUS_FREE_CYCLE + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLE + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_grant;
  logic              r_busy;
  logic              r_timeout;
  logic              r_scl_o;
  logic              r_sda_o;
  logic [FREE_W-1:0] r_free;
  logic [TO_W-1:0]   r_act;

  logic w_scl;
  logic w_sda;
  logic w_valid;
  logic w_start;
  logic w_stop;
  logic w_scl_edge;
  logic w_granted;
  logic w_bus_free;
  logic w_to_hit;
  logic w_force;

  peridot_i2c_cond_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cond_det (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_scl      (bus_scl_i),
    .i_sda      (bus_sda_i),
    .o_scl      (w_scl),
    .o_sda      (w_sda),
    .o_valid    (w_valid),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_edge (w_scl_edge)
  );

  assign w_granted  = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
  assign w_bus_free = (r_free == FREE_W'(BUS_FREE_CYCLE));
  // Fires on the last counted cycle so the forced release lands exactly TIMEOUT_CYCLE after the last SCL edge.
  assign w_to_hit   = (r_act == TO_W'(TIMEOUT_CYCLE - 1));
  assign w_force    = w_granted & w_to_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_bus_free && !r_busy && !w_start) begin
          if (m0_req && m1_req) w_state_nxt = r_last_grant ? ST_GRANT0 : ST_GRANT1;
          else if (m0_req)      w_state_nxt = ST_GRANT0;
          else if (m1_req)      w_state_nxt = ST_GRANT1;
        end
      end
      ST_GRANT0: if (w_to_hit || (!m0_req && !r_busy)) w_state_nxt = ST_RELEASE;
      ST_GRANT1: if (w_to_hit || (!m1_req && !r_busy)) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m0_grant  = (r_state == ST_GRANT0);
    m1_grant  = (r_state == ST_GRANT1);
    bus_scl_o = r_scl_o;
    bus_sda_o = r_sda_o;
    bus_busy  = r_busy;
    timeout   = r_timeout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_scl_o      <= 1'b1;
      r_sda_o      <= 1'b1;
      r_free       <= '0;
      r_act        <= '0;
    end else begin
      r_timeout <= w_force;

      if (w_force)      r_busy <= 1'b0;
      else if (w_start) r_busy <= 1'b1;
      else if (w_stop)  r_busy <= 1'b0;

      if (r_state == ST_GRANT0 && w_state_nxt == ST_RELEASE) r_last_grant <= 1'b0;
      if (r_state == ST_GRANT1 && w_state_nxt == ST_RELEASE) r_last_grant <= 1'b1;

      // Mux keyed on the next state so the pads follow the owner from the grant edge onward.
      case (w_state_nxt)
        ST_GRANT0: begin r_scl_o <= m0_scl_o; r_sda_o <= m0_sda_o; end
        ST_GRANT1: begin r_scl_o <= m1_scl_o; r_sda_o <= m1_sda_o; end
        default:   begin r_scl_o <= 1'b1;     r_sda_o <= 1'b1;     end
      endcase

      if (r_state == ST_RELEASE)                 r_free <= '0;
      else if (w_valid && !r_busy && w_scl && w_sda) begin
        if (!w_bus_free) r_free <= r_free + 1'b1;
      end else                                   r_free <= '0;

      if (!w_granted || w_scl_edge)             r_act <= '0;
      else if (r_act != TO_W'(TIMEOUT_CYCLE))   r_act <= r_act + 1'b1;
    end
  end

endmodule

// File: tb/tb_peridot_config_i2c_arb.sv
// Directed bench for the I2C bus arbiter; the pad is modelled as wired-AND of the arbiter drive and a foreign device.
module tb_peridot_config_i2c_arb;

  localparam int FREE = 64;
  localparam int TO   = 100;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m0_req = 1'b0, m0_scl_o = 1'b1, m0_sda_o = 1'b1;
  logic m1_req = 1'b0, m1_scl_o = 1'b1, m1_sda_o = 1'b1;
  logic ext_scl = 1'b1, ext_sda = 1'b1;
  logic bus_scl_i, bus_sda_i;
  logic m0_grant, m1_grant, bus_scl_o, bus_sda_o, bus_busy, timeout;

  int n_vec = 0;
  int n_err = 0;
  int n;

  assign bus_scl_i = bus_scl_o & ext_scl;
  assign bus_sda_i = bus_sda_o & ext_sda;

  always #5 clk = ~clk;

  peridot_config_i2c_arb #(
    .BUS_FREE_CYCLE (FREE),
    .TIMEOUT_CYCLE  (TO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m0_grant  (m0_grant),
    .m0_scl_o  (m0_scl_o),
    .m0_sda_o  (m0_sda_o),
    .m1_req    (m1_req),
    .m1_grant  (m1_grant),
    .m1_scl_o  (m1_scl_o),
    .m1_sda_o  (m1_sda_o),
    .bus_scl_i (bus_scl_i),
    .bus_sda_i (bus_sda_i),
    .bus_scl_o (bus_scl_o),
    .bus_sda_o (bus_sda_o),
    .bus_busy  (bus_busy),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic wait_grant(input int m, input int max, output int cnt);
    cnt = 0;
    while ((((m == 0) ? m0_grant : m1_grant) !== 1'b1) && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic drv(input int m, input logic scl, input logic sda, input int cnt);
    if (m == 0) begin m0_scl_o = scl; m0_sda_o = sda; end
    else        begin m1_scl_o = scl; m1_sda_o = sda; end
    tick(cnt);
  endtask

  task automatic i2c_start(input int m);
    drv(m, 1'b1, 1'b0, 4);
    drv(m, 1'b0, 1'b0, 4);
  endtask

  task automatic i2c_bit(input int m, input logic b);
    drv(m, 1'b0, b, 2);
    drv(m, 1'b1, b, 4);
    drv(m, 1'b0, b, 2);
  endtask

  task automatic i2c_byte(input int m, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) i2c_bit(m, d[i]);
    i2c_bit(m, 1'b1);
  endtask

  task automatic i2c_stop(input int m);
    drv(m, 1'b0, 1'b0, 2);
    drv(m, 1'b1, 1'b0, 4);
    drv(m, 1'b1, 1'b1, 6);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(1);
    check("rst_m0_grant", m0_grant, 0);
    check("rst_m1_grant", m1_grant, 0);
    check("rst_scl_o", bus_scl_o, 1);
    check("rst_sda_o", bus_sda_o, 1);
    check("rst_busy", bus_busy, 0);
    check("rst_timeout", timeout, 0);

    // 1: single request, grant after sync warm-up + free time + 1
    m0_req = 1'b1;
    do_reset();
    tick(FREE + SYNC);
    check("t1_grant_early", m0_grant, 0);
    tick(1);
    check("t1_grant_at_67", m0_grant, 1);
    check("t1_m1_grant", m1_grant, 0);
    m0_scl_o = 1'b0;
    check("t1_scl_delay", bus_scl_o, 1);
    tick(1);
    check("t1_scl_track_low", bus_scl_o, 0);
    m0_scl_o = 1'b1;
    tick(1);
    check("t1_scl_track_high", bus_scl_o, 1);
    m1_scl_o = 1'b0;
    tick(1);
    check("t1_m1_ignored", bus_scl_o, 1);
    m1_scl_o = 1'b1;
    m0_req = 1'b0;
    tick(1);
    check("t1_release", m0_grant, 0);

    // 2: tie after reset goes to m0, full transaction, then m1 after free time
    m0_req = 1'b1;
    m1_req = 1'b1;
    do_reset();
    wait_grant(0, 80, n);
    check("t2_tie_latency", n, FREE + SYNC + 1);
    check("t2_tie_m0", m0_grant, 1);
    check("t2_tie_m1", m1_grant, 0);
    i2c_start(0);
    check("t2_busy_start", bus_busy, 1);
    check("t2_sda_low", bus_sda_o, 0);
    i2c_byte(0, 8'hA5);
    i2c_byte(0, 8'h3C);
    check("t2_no_preempt", m1_grant, 0);
    i2c_stop(0);
    check("t2_busy_stop", bus_busy, 0);
    m0_req = 1'b0;
    tick(1);
    check("t2_m0_release", m0_grant, 0);
    tick(FREE + 1);
    check("t2_m1_early", m1_grant, 0);
    tick(1);
    check("t2_m1_grant", m1_grant, 1);
    m1_req = 1'b0;
    tick(1);
    check("t2_m1_release", m1_grant, 0);
    m0_req = 1'b1;
    m1_req = 1'b1;
    wait_grant(0, 80, n);
    check("t2_rr_m0", m0_grant, 1);
    check("t2_rr_m0_not_m1", m1_grant, 0);
    m0_req = 1'b0;
    tick(1);
    check("t2_rr_m0_drop", m0_grant, 0);
    m0_req = 1'b1;
    wait_grant(1, 80, n);
    check("t2_rr_m1", m1_grant, 1);
    check("t2_rr_m1_not_m0", m0_grant, 0);
    m1_req = 1'b0;
    wait_grant(0, 80, n);
    check("t3_m0_regrant", m0_grant, 1);

    // 3: request dropped mid-byte keeps grant until STOP
    i2c_start(0);
    for (int i = 0; i < 4; i++) i2c_bit(0, i[0]);
    m0_req = 1'b0;
    tick(2);
    check("t3_hold_mid", m0_grant, 1);
    for (int i = 0; i < 5; i++) i2c_bit(0, 1'b0);
    check("t3_hold_late", m0_grant, 1);
    drv(0, 1'b0, 1'b0, 2);
    drv(0, 1'b1, 1'b0, 4);
    drv(0, 1'b1, 1'b1, 0);
    n = 0;
    while (bus_busy !== 1'b0 && n < 20) begin tick(1); n++; end
    check("t3_busy_clear", bus_busy, 0);
    check("t3_grant_at_stop", m0_grant, 1);
    tick(1);
    check("t3_drop", m0_grant, 0);

    // 4: foreign START blocks grants until STOP + free time
    tick(FREE + 6);
    m1_scl_o = 1'b0;
    ext_sda = 1'b0;
    tick(5);
    check("t4_busy_foreign", bus_busy, 1);
    m1_req = 1'b1;
    tick(20);
    check("t4_blocked", m1_grant, 0);
    check("t4_drive_ignored", bus_scl_o, 1);
    ext_sda = 1'b1;
    tick(FREE + SYNC + 1);
    check("t4_grant_early", m1_grant, 0);
    tick(1);
    check("t4_grant", m1_grant, 1);

    // 5: m1 holds SCL low; counter restarts when the falling edge is seen after sync
    tick(TO + SYNC);
    check("t5_no_early_to", timeout, 0);
    check("t5_still_granted", m1_grant, 1);
    check("t5_scl_held", bus_scl_o, 0);
    tick(1);
    check("t5_timeout", timeout, 1);
    check("t5_grant_drop", m1_grant, 0);
    check("t5_scl_rel", bus_scl_o, 1);
    check("t5_sda_rel", bus_sda_o, 1);
    check("t5_busy", bus_busy, 0);
    m1_scl_o = 1'b1;
    tick(1);
    check("t5_pulse_width", timeout, 0);

    // 6: async reset in the middle of an m1 transaction
    wait_grant(1, 200, n);
    check("t6_regrant", m1_grant, 1);
    i2c_start(1);
    i2c_bit(1, 1'b0);
    check("t6_pre_sda", bus_sda_o, 0);
    check("t6_pre_busy", bus_busy, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_m1_grant", m1_grant, 0);
    check("t6_m0_grant", m0_grant, 0);
    check("t6_scl_o", bus_scl_o, 1);
    check("t6_sda_o", bus_sda_o, 1);
    check("t6_busy", bus_busy, 0);
    check("t6_timeout", timeout, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
